esp32_boot_sequencer: RTL and testbench
=======================================

// Module: esp32_boot_sequencer
// PURPOSE
//  Initiator side of the ESP32 DTR/RTS auto-reset protocol. Generates the nDTR/nRTS line sequence that a
//  host tool produces, plus the decoded EN/GPIO0 levels, so FPGA logic can reset the ESP32 into run or
//  bootloader mode without a USB host. Sits beside the wifi passthru. Drives wifi_en/wifi_gpio0 directly,
//  or feeds its ndtr/nrts into the existing DTR/RTS decoder.
// PARAMETERS
//  C_reset_cycles     2500000  EN-low hold in clk cycles (100 ms @25 MHz); 0 treated as 1
//  C_boot_cycles      1250000  GPIO0-low hold after EN release (50 ms); 0 treated as 1
//  C_gpio2_hold_bits  17       gpio2_hold lasts 2^N cycles from BOOT_HOLD entry
// PORTS
//  clk_25mhz   in   1  main clock, 25 MHz
//  reset       in   1  synchronous reset, active-high
//  start_boot  in   1  1-cycle request: reset ESP32 into bootloader (GPIO0 low at EN rise)
//  start_run   in   1  1-cycle request: plain reset, GPIO0 high at EN rise
//  ndtr        out  1  emulated FTDI nDTR pin level
//  nrts        out  1  emulated FTDI nRTS pin level
//  en          out  1  decoded ESP32 EN (0 = chip held in reset)
//  gpio0       out  1  decoded ESP32 GPIO0 strap
//  gpio2_hold  out  1  1 = drive ESP32 GPIO2 (sd_d[0]) low; else tri-state at top level
//  busy        out  1  sequence in progress; new starts ignored
//  done        out  1  1-cycle pulse on return to IDLE after a completed sequence
// BEHAVIOUR
//  - All outputs registered. Reset values: ndtr=1 nrts=1 en=1 gpio0=1 gpio2_hold=0 busy=0 done=0.
//  - Decode fixed, same truth table as passthru: (ndtr,nrts) 10 -> en=0,gpio0=1; 01 -> en=1,gpio0=0;
//    11 or 00 -> en=1,gpio0=1. en/gpio0 change in the same cycle as ndtr/nrts; never derived separately.
//  - FSM: IDLE, RESET_HOLD, BOOT_HOLD, RELEASE_WAIT.
//   IDLE: lines 11, busy=0. start_boot or start_run at edge T -> RESET_HOLD from T+1; busy=1 from T+1.
//     Both starts in the same cycle: boot wins. Starts while busy are dropped, not queued.
//   RESET_HOLD: lines 10 for exactly C_reset_cycles cycles.
//     Then BOOT_HOLD if boot request, else RELEASE_WAIT.
//   BOOT_HOLD: lines 01 for exactly C_boot_cycles cycles; no intermediate 11 between 10 and 01.
//     Entry loads the gpio2 counter: gpio2_hold=1 for exactly 2^C_gpio2_hold_bits cycles from entry,
//     independent of state. Then RELEASE_WAIT.
//   RELEASE_WAIT: lines 11. Leaves when gpio2_hold=0; run path leaves after 1 cycle.
//     On leaving: done=1 for 1 cycle, busy=0 in that same cycle, state IDLE.
//  - Phase counter: down-counter, width $clog2(max(C_reset_cycles,C_boot_cycles)+1).
//    Loaded on state entry, terminal at 1, no wrap. gpio2 counter: C_gpio2_hold_bits+1 bits, MSB = expired.
//  - reset asserted mid-sequence: next edge -> IDLE, all outputs to reset values, counters cleared;
//    no done pulse. Run sequence never asserts gpio2_hold.
// STRUCTURE
//  - Shared package esp32_ctl_pkg: FSM state typedef; localparams LINES_IDLE=2'b11, LINES_RESET=2'b10,
//    LINES_BOOT=2'b01; function dtr_rts_decode(ndtr,nrts)->{en,gpio0}. The passthru decoder reuses it.
//  - One sub-module, esp32_hold_timer: loadable down-counter with load/value/expired; instantiated for
//    phase timing. The gpio2 counter stays inline.
// TESTING (bench overrides C_reset_cycles=8, C_boot_cycles=4, C_gpio2_hold_bits=4)
//  1 start_boot pulse at T -> lines 10 for T+1..T+8, 01 for T+9..T+12, gpio2_hold=1 for T+9..T+24,
//    done at T+25, busy=0 at T+25.
//  2 start_run pulse -> lines 10 for 8 cycles, then 11; gpio0 never 0; gpio2_hold never 1;
//    done 1 cycle after release.
//  3 start_boot and start_run same cycle -> boot sequence as scenario 1; extra starts during busy ignored,
//    exactly one done.
//  4 reset asserted on cycle 3 of BOOT_HOLD -> next edge: lines 11, en=1, gpio0=1, gpio2_hold=0, busy=0,
//    no done; new start_boot then gives a full scenario 1 timing.
//  5 every cycle: {en,gpio0} == dtr_rts_decode(ndtr,nrts); lines never 00; en=0 implies gpio0=1.
//  6 C_reset_cycles=0, C_boot_cycles=0 -> each phase lasts exactly 1 cycle; no hang, done still pulses.

Source files
------------

// File: rtl/esp32_ctl_pkg.sv
// Shared ESP32 control definitions: boot FSM states, DTR/RTS line codes and
// the auto-reset line decode used by both the boot sequencer and the passthru.
package esp32_ctl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET_HOLD,
    S_BOOT_HOLD,
    S_RELEASE_WAIT
  } boot_state_t;

  localparam logic [1:0] LINES_IDLE  = 2'b11;
  localparam logic [1:0] LINES_RESET = 2'b10;
  localparam logic [1:0] LINES_BOOT  = 2'b01;

  // Returns {en, gpio0}; the 00 and 11 line pairs both leave the chip running.
  function automatic logic [1:0] dtr_rts_decode(input logic ndtr, input logic nrts);
    case ({ndtr, nrts})
      2'b10:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Returns {ndtr, nrts, en, gpio0} so lines and decoded pins load together.
  function automatic logic [3:0] line_word(input logic [1:0] lines);
    return {lines, dtr_rts_decode(lines[1], lines[0])};
  endfunction

endpackage

// File: rtl/esp32_hold_timer.sv
// Loadable down-counter for phase timing; stops at 1 (no wrap) and reports
// expired while the count is at or below 1.
module esp32_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk_25mhz,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk_25mhz) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (count > W'(1))
      count <= count - 1'b1;
  end

  assign expired = (count <= W'(1));

endmodule

// File: rtl/esp32_boot_sequencer.sv
// Emulates the host DTR/RTS auto-reset sequence so FPGA logic can put the
// ESP32 into run or bootloader mode, with decoded EN/GPIO0 and a GPIO2 strap hold.
module esp32_boot_sequencer
  import esp32_ctl_pkg::*;
#(
  parameter int C_reset_cycles    = 2500000,
  parameter int C_boot_cycles     = 1250000,
  parameter int C_gpio2_hold_bits = 17
) (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic start_boot,
  input  logic start_run,
  output logic ndtr,
  output logic nrts,
  output logic en,
  output logic gpio0,
  output logic gpio2_hold,
  output logic busy,
  output logic done
);

  // A zero-length phase still occupies one cycle.
  localparam int RESET_LD = (C_reset_cycles < 1) ? 1 : C_reset_cycles;
  localparam int BOOT_LD  = (C_boot_cycles < 1) ? 1 : C_boot_cycles;
  localparam int PH_MAX   = (RESET_LD > BOOT_LD) ? RESET_LD : BOOT_LD;
  localparam int PH_W     = $clog2(PH_MAX + 1);
  localparam int G2_W     = C_gpio2_hold_bits + 1;
  localparam logic [G2_W-1:0] G2_EXPIRED = G2_W'(1) << C_gpio2_hold_bits;

  boot_state_t     state;
  logic            boot_req;
  logic            start_any;
  logic            boot_entry;
  logic            ph_load;
  logic [PH_W-1:0] ph_value;
  logic            ph_expired;
  logic [G2_W-1:0] g2_cnt;
  logic [G2_W-1:0] g2_next;

  assign start_any  = start_boot | start_run;
  assign boot_entry = (state == S_RESET_HOLD) && ph_expired && boot_req;
  assign ph_load    = ((state == S_IDLE) && start_any) || boot_entry;
  assign ph_value   = (state == S_IDLE) ? PH_W'(RESET_LD) : PH_W'(BOOT_LD);

  // GPIO2 hold counts up from 0 on BOOT_HOLD entry; the MSB marks expiry.
  assign g2_next = boot_entry         ? '0 :
                   !g2_cnt[G2_W-1]    ? g2_cnt + 1'b1 :
                                        g2_cnt;

  esp32_hold_timer #(.W(PH_W)) u_phase_timer (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .load      (ph_load),
    .value     (ph_value),
    .expired   (ph_expired)
  );

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state                  <= S_IDLE;
      boot_req               <= 1'b0;
      {ndtr, nrts, en, gpio0} <= line_word(LINES_IDLE);
      busy                   <= 1'b0;
      done                   <= 1'b0;
      g2_cnt                 <= G2_EXPIRED;
      gpio2_hold             <= 1'b0;
    end else begin
      done       <= 1'b0;
      g2_cnt     <= g2_next;
      gpio2_hold <= ~g2_next[G2_W-1];
      case (state)
        S_IDLE: begin
          if (start_any) begin
            state                  <= S_RESET_HOLD;
            boot_req               <= start_boot;
            {ndtr, nrts, en, gpio0} <= line_word(LINES_RESET);
            busy                   <= 1'b1;
          end
        end
        S_RESET_HOLD: begin
          // Go straight from 10 to 01 so the chip never sees a released EN with GPIO0 high.
          if (ph_expired) begin
            if (boot_req) begin
              state                  <= S_BOOT_HOLD;
              {ndtr, nrts, en, gpio0} <= line_word(LINES_BOOT);
            end else begin
              state                  <= S_RELEASE_WAIT;
              {ndtr, nrts, en, gpio0} <= line_word(LINES_IDLE);
            end
          end
        end
        S_BOOT_HOLD: begin
          if (ph_expired) begin
            state                  <= S_RELEASE_WAIT;
            {ndtr, nrts, en, gpio0} <= line_word(LINES_IDLE);
          end
        end
        S_RELEASE_WAIT: begin
          // Leave on the same edge the GPIO2 hold drops, so done coincides with its release.
          if (g2_next[G2_W-1]) begin
            state    <= S_IDLE;
            boot_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Bench for esp32_boot_sequencer: a cycle-offset model of the boot/run sequences
// checked every cycle on two instances, plus literal timing pins for the boot path.
module tb_esp32_boot_sequencer;

  localparam int RA = 8, BA = 4, HOLD = 16;
  localparam int RB = 1, BB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic sb_a = 1'b0, sr_a = 1'b0, sb_b = 1'b0, sr_b = 1'b0;
  logic ndtr_a, nrts_a, en_a, g0_a, g2_a, busy_a, done_a;
  logic ndtr_b, nrts_b, en_b, g0_b, g2_b, busy_b, done_b;

  esp32_boot_sequencer #(.C_reset_cycles(8), .C_boot_cycles(4), .C_gpio2_hold_bits(4)) dut_a (
    .clk_25mhz(clk), .reset(rst), .start_boot(sb_a), .start_run(sr_a),
    .ndtr(ndtr_a), .nrts(nrts_a), .en(en_a), .gpio0(g0_a),
    .gpio2_hold(g2_a), .busy(busy_a), .done(done_a));

  esp32_boot_sequencer #(.C_reset_cycles(0), .C_boot_cycles(0), .C_gpio2_hold_bits(4)) dut_b (
    .clk_25mhz(clk), .reset(rst), .start_boot(sb_b), .start_run(sr_b),
    .ndtr(ndtr_b), .nrts(nrts_b), .en(en_b), .gpio0(g0_b),
    .gpio2_hold(g2_b), .busy(busy_b), .done(done_b));

  // Model: k = cycles since the accepted start (1 = first cycle after the start edge), 0 = idle.
  function automatic int done_k(input bit boot, input int r, input int b, input int hold);
    int x, y;
    x = r + b + 2;
    y = r + hold + 1;
    if (!boot) return r + 2;
    return (x > y) ? x : y;
  endfunction

  // Returns {ndtr, nrts, en, gpio0, gpio2_hold, busy, done}.
  function automatic logic [6:0] exp_out(input int k, input bit boot, input int r, input int b, input int hold);
    logic [1:0] ln;
    int dk;
    dk = done_k(boot, r, b, hold);
    if (k >= 1 && k <= r) ln = 2'b10;
    else if (boot && k > r && k <= r + b) ln = 2'b01;
    else ln = 2'b11;
    return {ln, ln != 2'b10, ln != 2'b01,
            boot && k > r && k <= r + hold,
            k >= 1 && k < dk,
            k == dk};
  endfunction

  int cyc = 0;
  int k_a = 0, k_b = 0;
  bit boot_a = 1'b0, boot_b = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) k_a <= 0;
    else if ((k_a == 0 || k_a == done_k(boot_a, RA, BA, HOLD)) && (sb_a || sr_a)) begin
      k_a <= 1; boot_a <= sb_a;
    end else if (k_a == done_k(boot_a, RA, BA, HOLD)) k_a <= 0;
    else if (k_a > 0) k_a <= k_a + 1;

    if (rst) k_b <= 0;
    else if ((k_b == 0 || k_b == done_k(boot_b, RB, BB, HOLD)) && (sb_b || sr_b)) begin
      k_b <= 1; boot_b <= sb_b;
    end else if (k_b == done_k(boot_b, RB, BB, HOLD)) k_b <= 0;
    else if (k_b > 0) k_b <= k_b + 1;
  end

  // Hand-computed boot-path timing relative to the start cycle.
  localparam int NLIT = 9;
  int         lit_off [NLIT] = '{0, 1, 8, 9, 12, 13, 24, 25, 26};
  logic [6:0] lit_val [NLIT] = '{7'b1111000, 7'b1001010, 7'b1001010, 7'b0110110, 7'b0110110,
                                 7'b1111110, 7'b1111110, 7'b1111001, 7'b1111000};

  bit lit_on = 1'b0, end_chk = 1'b0, end_done = 1'b0;
  int mark = -100;
  int n_tests = 0, n_fail = 0;
  int nd_a = 0, nd_b = 0;
  logic [6:0] act_a, act_b, want_a, want_b;

  always @(negedge clk) begin
    act_a  = {ndtr_a, nrts_a, en_a, g0_a, g2_a, busy_a, done_a};
    act_b  = {ndtr_b, nrts_b, en_b, g0_b, g2_b, busy_b, done_b};
    want_a = exp_out(k_a, boot_a, RA, BA, HOLD);
    want_b = exp_out(k_b, boot_b, RB, BB, HOLD);
    n_tests += 2;
    if (act_a !== want_a) begin
      n_fail++;
      $display("FAIL model_a cyc=%0d k=%0d got=%b want=%b", cyc, k_a, act_a, want_a);
    end
    if (act_b !== want_b) begin
      n_fail++;
      $display("FAIL model_b cyc=%0d k=%0d got=%b want=%b", cyc, k_b, act_b, want_b);
    end
    n_tests += 2;
    if ({ndtr_a, nrts_a} == 2'b00 || (!en_a && !g0_a)) begin
      n_fail++;
      $display("FAIL invariant_a cyc=%0d got=%b", cyc, act_a);
    end
    if ({ndtr_b, nrts_b} == 2'b00 || (!en_b && !g0_b)) begin
      n_fail++;
      $display("FAIL invariant_b cyc=%0d got=%b", cyc, act_b);
    end
    if (lit_on) begin
      for (int i = 0; i < NLIT; i++) begin
        if (cyc - mark == lit_off[i]) begin
          n_tests++;
          if (act_a !== lit_val[i]) begin
            n_fail++;
            $display("FAIL literal_off%0d got=%b want=%b", lit_off[i], act_a, lit_val[i]);
          end
        end
      end
    end
    if (done_a) nd_a++;
    if (done_b) nd_b++;
    if (end_chk && !end_done) begin
      end_done = 1'b1;
      n_tests += 2;
      if (nd_a != 4) begin
        n_fail++;
        $display("FAIL done_count_a got=%0d want=4", nd_a);
      end
      if (nd_b != 2) begin
        n_fail++;
        $display("FAIL done_count_b got=%0d want=2", nd_b);
      end
    end
  end

  task automatic go(input logic b, input logic r, input bit to_b);
    @(posedge clk); #2;
    if (to_b) begin sb_b = b; sr_b = r; end
    else begin sb_a = b; sr_a = r; mark = cyc; end
    @(posedge clk); #2;
    sb_a = 1'b0; sr_a = 1'b0; sb_b = 1'b0; sr_b = 1'b0;
  endtask

  task automatic pulse_a(input logic b, input logic r);
    @(posedge clk); #2;
    sb_a = b; sr_a = r;
    @(posedge clk); #2;
    sb_a = 1'b0; sr_a = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    wait_cyc(3); #2 rst = 1'b0;
    wait_cyc(2);
    // boot sequence with literal timing
    lit_on = 1'b1; go(1'b1, 1'b0, 1'b0); wait_cyc(30); lit_on = 1'b0;
    // run sequence
    go(1'b0, 1'b1, 1'b0); wait_cyc(14);
    // simultaneous starts, then starts while busy
    lit_on = 1'b1; go(1'b1, 1'b1, 1'b0);
    wait_cyc(2); pulse_a(1'b0, 1'b1);
    wait_cyc(6); pulse_a(1'b1, 1'b0);
    wait_cyc(25); lit_on = 1'b0;
    // reset during the third BOOT_HOLD cycle, then a full boot again
    go(1'b1, 1'b0, 1'b0);
    wait_cyc(10); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    wait_cyc(3);
    lit_on = 1'b1; go(1'b1, 1'b0, 1'b0); wait_cyc(30); lit_on = 1'b0;
    // zero-length phases
    go(1'b1, 1'b0, 1'b1); wait_cyc(22);
    go(1'b0, 1'b1, 1'b1); wait_cyc(6);
    end_chk = 1'b1;
    wait_cyc(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
